instr_fetch_unit: RTL and testbench

Front-end stage that feeds the processor datapath: it debounces the board keys, loads 16-bit instruction words from the switches into a 16-entry program store, and then fetches and decodes them one at a time into register addresses, opcode and zero-extended immediate. Decoded instructions are presented to the control unit, register bank and ALU through a valid/ready handshake, in either single-step or free-run mode.

---
 rtl/instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front end of the processor: debounces the board keys, loads 16-bit
// instruction words from the switches into a small program store, then
// fetches and decodes one instruction at a time and presents it downstream
// through a valid/ready handshake, either single-step or free-run.
//
// Ports
//   clk          : 50 MHz system clock, rising edge
//   reset        : asynchronous, active-high
//   key_load     : raw key, active-low; appends sw_instr to the store
//   key_step     : raw key, active-low; issues the next instruction
//   key_run      : raw key, active-low; runs the program from address 0
//   sw_instr     : instruction word from the switches
//   instr_ready  : downstream accepts the presented instruction
//   instr_valid  : decoded instruction is presented
//   opcode/rc/ra/rb : instruction fields [15:12]/[11:8]/[7:4]/[3:0]
//   imm          : ra field zero-extended to 16 bits
//   flag_imm     : opcode is in the immediate range 6..10
//   pc           : address of the next instruction
//   count        : number of loaded words, 0..DEPTH
//   full         : count == DEPTH
//   halted       : a HALT instruction has been fetched
//
// States
//   S_IDLE  | waiting for key pulses; loads happen only here
//   S_FETCH | reads mem[pc]; skips reserved opcodes, stops on HALT
//   S_ISSUE | instruction presented, waiting for instr_ready
//   S_HALT  | HALT fetched; run restarts, load clears the program
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int DEPTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int AW             = $clog2(DEPTH),
  localparam int CW             = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_load,
  input  logic          key_step,
  input  logic          key_run,
  input  logic [15:0]   sw_instr,
  input  logic          instr_ready,
  output logic          instr_valid,
  output logic [3:0]    opcode,
  output logic [3:0]    rc,
  output logic [3:0]    ra,
  output logic [3:0]    rb,
  output logic [15:0]   imm,
  output logic          flag_imm,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          halted
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Key synchronizers and debouncers. index 0 = load, 1 = step, 2 = run.
  // ---------------------------------------------------------------------------
  logic [2:0] key_raw;
  logic [2:0] press;

  assign key_raw = {key_run, key_step, key_load};

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic           sync1_q;
    logic           sync2_q;
    logic           level_q;
    logic           press_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= key_raw[k];
        sync2_q <= sync1_q;
        press_q <= 1'b0;
        // Any return to the accepted level restarts the stability window.
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q   <= '0;
          level_q <= sync2_q;
          press_q <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[k] = press_q;
  end

  // Only the highest-priority pulse of a cycle survives.
  logic load_p, step_p, run_p;
  assign load_p = press[0];
  assign step_p = press[1] & ~press[0];
  assign run_p  = press[2] & ~press[1] & ~press[0];

  // ---------------------------------------------------------------------------
  // Program store
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

  state_t         state_q;
  logic [AW-1:0]  pc_q;
  logic [CW-1:0]  count_q;
  logic           run_q;
  logic [15:0]    instr_q;
  logic           valid_q;
  logic           halted_q;

  logic [15:0]    mem [DEPTH];
  logic           mem_we;
  logic [15:0]    fetch_word;
  logic [3:0]     fetch_op;
  logic [CW-1:0]  pc_inc;
  logic           more;

  assign mem_we     = (state_q == S_IDLE) && load_p && (count_q < CW'(DEPTH));
  assign fetch_word = mem[pc_q];
  assign fetch_op   = fetch_word[15:12];

  // End of program is judged on the widened pc+1 so a full store ends
  // cleanly even though the 4-bit pc wraps to 0.
  assign pc_inc = {1'b0, pc_q} + 1'b1;
  assign more   = run_q && (pc_inc < count_q);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= sw_instr;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_p) begin
            if (count_q < CW'(DEPTH)) begin
              count_q <= count_q + 1'b1;
            end
          end else if (step_p) begin
            if ({1'b0, pc_q} < count_q) begin
              run_q   <= 1'b0;
              state_q <= S_FETCH;
            end
          end else if (run_p) begin
            if (count_q != '0) begin
              pc_q    <= '0;
              run_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (fetch_op == 4'd15) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (fetch_op >= 4'd11) begin
            pc_q    <= pc_q + 1'b1;
            state_q <= more ? S_FETCH : S_IDLE;
          end else begin
            // The decoded outputs only ever change here.
            instr_q <= fetch_word;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            pc_q    <= pc_q + 1'b1;
            state_q <= more ? S_FETCH : S_IDLE;
          end
        end

        S_HALT: begin
          if (load_p) begin
            count_q  <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (run_p) begin
            pc_q     <= '0;
            run_q    <= 1'b1;
            halted_q <= 1'b0;
            state_q  <= S_FETCH;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_valid = valid_q;
  assign opcode      = instr_q[15:12];
  assign rc          = instr_q[11:8];
  assign ra          = instr_q[7:4];
  assign rb          = instr_q[3:0];
  assign imm         = {12'd0, instr_q[7:4]};
  assign flag_imm    = (instr_q[15:12] >= 4'd6) && (instr_q[15:12] <= 4'd10);
  assign pc          = pc_q;
  assign count       = count_q;
  assign full        = (count_q == CW'(DEPTH));
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_load, key_step, key_run;
  logic [15:0] sw_instr;
  logic        instr_ready;
  logic        instr_valid;
  logic [3:0]  opcode, rc, ra, rb;
  logic [15:0] imm;
  logic        flag_imm;
  logic [3:0]  pc;
  logic [4:0]  count;
  logic        full;
  logic        halted;

  instr_fetch_unit #(.DEPTH(16), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset),
    .key_load(key_load), .key_step(key_step), .key_run(key_run),
    .sw_instr(sw_instr), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .opcode(opcode), .rc(rc), .ra(ra), .rb(rb),
    .imm(imm), .flag_imm(flag_imm), .pc(pc), .count(count),
    .full(full), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] instr;
    bit          issued;
    logic [3:0]  op, rc, ra, rb;
    logic [15:0] imm;
    bit          fimm;
  } vec_t;

  vec_t        vt [16];
  logic [32:0] sb_q [$];
  logic [32:0] sb_exp;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] pack_exp(input vec_t v);
    return {v.op, v.rc, v.ra, v.rb, v.imm, v.fimm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keys held low long enough for one accepted press; returns just after the
  // clock edge on which the sequencer consumed the pulse.
  task automatic press(input bit l, input bit s, input bit r);
    repeat (8) tick();
    key_load = ~l;
    key_step = ~s;
    key_run  = ~r;
    repeat (DB + 3) @(posedge clk);
    #1;
    key_load = 1'b1;
    key_step = 1'b1;
    key_run  = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 40'(sb_q.size()), 40'd0);
  endtask

  // Scoreboard: every transfer must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got transfer of opcode %0h, expected none", opcode);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_issue", {7'd0, opcode, rc, ra, rb, imm, flag_imm}, {7'd0, sb_exp});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{16'h0123, 1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 16'h0002, 1'b0};
    vt[1]  = '{16'h1456, 1'b1, 4'h1, 4'h4, 4'h5, 4'h6, 16'h0005, 1'b0};
    vt[2]  = '{16'hB000, 1'b0, 4'hB, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0};
    vt[3]  = '{16'h2789, 1'b1, 4'h2, 4'h7, 4'h8, 4'h9, 16'h0008, 1'b0};
    vt[4]  = '{16'h3ABC, 1'b1, 4'h3, 4'hA, 4'hB, 4'hC, 16'h000B, 1'b0};
    vt[5]  = '{16'h4DEF, 1'b1, 4'h4, 4'hD, 4'hE, 4'hF, 16'h000E, 1'b0};
    vt[6]  = '{16'hC111, 1'b0, 4'hC, 4'h1, 4'h1, 4'h1, 16'h0001, 1'b0};
    vt[7]  = '{16'h5F0E, 1'b1, 4'h5, 4'hF, 4'h0, 4'hE, 16'h0000, 1'b0};
    vt[8]  = '{16'h6A45, 1'b1, 4'h6, 4'hA, 4'h4, 4'h5, 16'h0004, 1'b1};
    vt[9]  = '{16'h7F9C, 1'b1, 4'h7, 4'hF, 4'h9, 4'hC, 16'h0009, 1'b1};
    vt[10] = '{16'h8E8D, 1'b1, 4'h8, 4'hE, 4'h8, 4'hD, 16'h0008, 1'b1};
    vt[11] = '{16'hD222, 1'b0, 4'hD, 4'h2, 4'h2, 4'h2, 16'h0002, 1'b0};
    vt[12] = '{16'h9B7A, 1'b1, 4'h9, 4'hB, 4'h7, 4'hA, 16'h0007, 1'b1};
    vt[13] = '{16'hA3F1, 1'b1, 4'hA, 4'h3, 4'hF, 4'h1, 16'h000F, 1'b1};
    vt[14] = '{16'h0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0};
    vt[15] = '{16'hE333, 1'b0, 4'hE, 4'h3, 4'h3, 4'h3, 16'h0003, 1'b0};

    reset = 1'b1;
    key_load = 1'b1;
    key_step = 1'b1;
    key_run  = 1'b1;
    sw_instr = 16'h0;
    instr_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_halted", halted, 0);
    check("rst_fields", {opcode, rc, ra, rb, imm}, 0);
    reset = 1'b0;

    // Loads
    sw_instr = 16'h0123; press(1, 0, 0);
    check("load1_count", count, 1);
    sw_instr = 16'h6A45; press(1, 0, 0);
    sw_instr = 16'hF000; press(1, 0, 0);
    check("load3_count", count, 3);
    check("load3_full", full, 0);
    sw_instr = 16'h2789; press(1, 0, 0);
    check("load4_count", count, 4);

    // Single step
    press(0, 1, 0);
    check("step1_fetch_valid", instr_valid, 0);
    tick();
    check("step1_valid", instr_valid, 1);
    check("step1_fields", {opcode, rc, ra, rb, flag_imm}, {4'h0, 4'h1, 4'h2, 4'h3, 1'b0});
    sb_q.push_back({4'h0, 4'h1, 4'h2, 4'h3, 16'h0002, 1'b0});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("step1_pc", pc, 1);
    check("step1_idle_valid", instr_valid, 0);

    // Immediate decode
    press(0, 1, 0);
    tick();
    check("step2_valid", instr_valid, 1);
    check("step2_fields", {opcode, rc, rb, imm, flag_imm}, {4'h6, 4'hA, 4'h5, 16'h0004, 1'b1});
    sb_q.push_back({4'h6, 4'hA, 4'h4, 4'h5, 16'h0004, 1'b1});
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("step2_pc", pc, 2);

    // HALT reached by stepping
    press(0, 1, 0);
    tick();
    check("halt_flag", halted, 1);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc, 2);
    check("halt_fields_held", opcode, 6);
    press(0, 1, 0);
    tick();
    check("halt_step_ignored", {halted, instr_valid, pc}, {1'b1, 1'b0, 4'd2});

    // Back-pressure in run mode, started from HALT
    sb_q.push_back({4'h0, 4'h1, 4'h2, 4'h3, 16'h0002, 1'b0});
    sb_q.push_back({4'h6, 4'hA, 4'h4, 4'h5, 16'h0004, 1'b1});
    press(0, 0, 1);
    check("bp_fetch", {instr_valid, halted, pc}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", instr_valid, 1);
      check("bp_fields", {opcode, rc, ra, rb}, 16'h0123);
      check("bp_pc", pc, 0);
    end
    instr_ready = 1'b1;
    tick();
    check("bp_xfer_pc", pc, 1);
    check("bp_gap_valid", instr_valid, 0);
    tick();
    check("bp_next_valid", instr_valid, 1);
    check("bp_next_op", opcode, 6);
    repeat (2) tick();
    check("bp_end_halt", {halted, instr_valid, pc}, {1'b1, 1'b0, 4'd2});
    check("bp_sb_empty", 40'(sb_q.size()), 0);
    instr_ready = 1'b0;

    // Load in HALT clears the program
    sw_instr = 16'hFFFF; press(1, 0, 0);
    check("halt_load_clear", {halted, pc, count}, 0);

    // Table: fill the store, then run it through the scoreboard
    for (int i = 0; i < 16; i++) begin
      sw_instr = vt[i].instr;
      press(1, 0, 0);
      check("tbl_count", count, 40'(i + 1));
      check("tbl_full", full, 40'(i == 15));
      if (vt[i].issued) sb_q.push_back(pack_exp(vt[i]));
    end
    sw_instr = 16'h3FFF; press(1, 0, 0);
    check("full_17th_count", count, 16);
    check("full_17th_full", full, 1);
    instr_ready = 1'b1;
    press(0, 0, 1);
    drain("tbl_drain", 200);
    repeat (4) tick();
    check("tbl_end", {instr_valid, halted, pc, count}, {1'b0, 1'b0, 4'd0, 5'd16});
    instr_ready = 1'b0;

    // Reserved opcode adds one cycle; then reset while in ISSUE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_count", count, 0);
    sw_instr = 16'hB000; press(1, 0, 0);
    sw_instr = 16'h1456; press(1, 0, 0);
    press(0, 0, 1);
    check("rsv_fetch_valid", instr_valid, 0);
    tick();
    check("rsv_skip_valid", instr_valid, 0);
    check("rsv_skip_pc", pc, 1);
    tick();
    check("rsv_issue_valid", instr_valid, 1);
    check("rsv_issue_fields", {opcode, rc, ra, rb}, 16'h1456);
    check("rsv_issue_pc", pc, 1);
    reset = 1'b1;
    #1;
    check("rst_issue_valid", instr_valid, 0);
    check("rst_issue_pc_count", {pc, count}, 0);
    tick();
    reset = 1'b0;

    // 3-cycle glitch on the load key
    tick();
    key_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    key_load = 1'b1;
    repeat (12) tick();
    check("glitch_count", count, 0);

    // Simultaneous load and run: load wins
    sw_instr = 16'h1456; press(1, 0, 0);
    check("prio_pre_count", count, 1);
    sw_instr = 16'h2789; press(1, 0, 1);
    check("prio_count", count, 2);
    check("prio_pc", pc, 0);
    repeat (3) tick();
    check("prio_no_run", instr_valid, 0);

    // Run to program end, then restart from 0
    sb_q.push_back({4'h1, 4'h4, 4'h5, 4'h6, 16'h0005, 1'b0});
    sb_q.push_back({4'h2, 4'h7, 4'h8, 4'h9, 16'h0008, 1'b0});
    instr_ready = 1'b1;
    press(0, 0, 1);
    drain("run1_drain", 50);
    repeat (2) tick();
    check("run1_end_pc", pc, 2);
    check("run1_end_valid", instr_valid, 0);
    press(0, 1, 0);
    tick();
    check("step_at_end_ignored", {instr_valid, pc}, {1'b0, 4'd2});
    sb_q.push_back({4'h1, 4'h4, 4'h5, 4'h6, 16'h0005, 1'b0});
    sb_q.push_back({4'h2, 4'h7, 4'h8, 4'h9, 16'h0008, 1'b0});
    press(0, 0, 1);
    drain("run2_drain", 50);
    repeat (2) tick();
    check("run2_end_pc", pc, 2);
    instr_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
